// File: rtl/mcoi_gbt_cmd_decoder.sv
// GBT RX command decoder: header lock FSM, CRC/sequence checks and a command FIFO presented as valid/ready writes.
// Optional macro GBT_CMD_CRC_CHECK_EN enables the CRC-8 check of data[7:0]; when undefined every frame is CRC-OK.
module mcoi_gbt_cmd_decoder #(
  parameter int         FIFO_DEPTH = 8,
  parameter int         LOCK_CNT   = 4,
  parameter int         UNLOCK_CNT = 4,
  parameter logic [7:0] HEADER     = 8'hA5
) (
  input  logic        clk_ik,
  input  logic        rstn_ir,
  input  logic        rx_ready_i,
  input  logic        frame_valid_i,
  input  logic [83:0] frame_i,
  output logic        cmd_valid_o,
  input  logic        cmd_ready_i,
  output logic [7:0]  cmd_addr_o,
  output logic [31:0] cmd_data_o,
  output logic        locked_o,
  output logic [15:0] crc_err_cnt_o,
  output logic [15:0] seq_err_cnt_o,
  output logic [15:0] drop_cnt_o
);

  localparam int AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW      = AW + 1;
  localparam int NUM_CNT = 2;

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t        state_reg, state_next;
  logic [7:0]    run_reg, run_next;
  logic          stage_valid_reg;
  logic [79:0]   stage_data_reg;
  logic          seq_valid_reg;
  logic [7:0]    expected_reg;
  logic [39:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg;

  logic          hdr_ok, crc_ok, decode, crc_fail, is_write, seq_bad;
  logic          pop, full, push_ok, drop;
  logic [39:0]   head;
  logic [NUM_CNT-1:0] cnt_inc;
  logic          unused_bits;

  // Frame stage: everything downstream works on the registered copy.
  always_ff @(posedge clk_ik) begin
    if (!rstn_ir) begin
      stage_valid_reg <= 1'b0;
      stage_data_reg  <= '0;
    end else begin
      stage_valid_reg <= frame_valid_i & rx_ready_i;
      stage_data_reg  <= frame_i[79:0];
    end
  end

`ifdef GBT_CMD_CRC_CHECK_EN
  function automatic logic [7:0] crc8(input logic [71:0] d);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int i = 71; i >= 0; i--) begin
      fb = c[7] ^ d[i];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  assign crc_ok = (crc8(stage_data_reg[79:8]) == stage_data_reg[7:0]);
`else
  assign crc_ok = 1'b1;
`endif

  assign hdr_ok   = (stage_data_reg[79:72] == HEADER);
  assign decode   = stage_valid_reg & rx_ready_i & (state_reg == LOCKED) & hdr_ok;
  assign crc_fail = decode & ~crc_ok;
  assign is_write = decode & crc_ok & (stage_data_reg[63:56] == 8'h01);
  assign seq_bad  = is_write & seq_valid_reg & (stage_data_reg[71:64] != expected_reg);

  always_ff @(posedge clk_ik) begin
    if (!rstn_ir) begin
      state_reg <= HUNT;
      run_reg   <= '0;
    end else begin
      state_reg <= state_next;
      run_reg   <= run_next;
    end
  end

  // run_reg counts good headers in HUNT and bad headers in LOCKED.
  always_comb begin
    state_next = state_reg;
    run_next   = run_reg;
    if (!rx_ready_i) begin
      state_next = HUNT;
      run_next   = '0;
    end else if (stage_valid_reg) begin
      case (state_reg)
        HUNT: begin
          if (!hdr_ok) begin
            run_next = '0;
          end else if (run_reg == 8'(LOCK_CNT - 1)) begin
            state_next = LOCKED;
            run_next   = '0;
          end else begin
            run_next = run_reg + 8'd1;
          end
        end
        LOCKED: begin
          if (hdr_ok) begin
            run_next = '0;
          end else if (run_reg == 8'(UNLOCK_CNT - 1)) begin
            state_next = HUNT;
            run_next   = '0;
          end else begin
            run_next = run_reg + 8'd1;
          end
        end
        default: begin
          state_next = HUNT;
          run_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_ik) begin
    if (!rstn_ir) begin
      seq_valid_reg <= 1'b0;
      expected_reg  <= '0;
    end else if (!rx_ready_i) begin
      seq_valid_reg <= 1'b0;
    end else if (is_write) begin
      seq_valid_reg <= 1'b1;
      expected_reg  <= stage_data_reg[71:64] + 8'd1;
    end
  end

  // A push into a full FIFO still lands when the head is popped in the same cycle.
  assign cmd_valid_o = (count_reg != '0);
  assign pop         = cmd_valid_o & cmd_ready_i;
  assign full        = (count_reg == CW'(FIFO_DEPTH));
  assign push_ok     = is_write & (~full | pop);
  assign drop        = is_write & full & ~pop;

  always_ff @(posedge clk_ik) begin
    if (push_ok) mem[wr_ptr_reg] <= stage_data_reg[55:16];
  end

  always_ff @(posedge clk_ik) begin
    if (!rstn_ir) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)     rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + CW'(push_ok) - CW'(pop);
    end
  end

  assign head       = mem[rd_ptr_reg];
  assign cmd_addr_o = cmd_valid_o ? head[39:32] : 8'h00;
  assign cmd_data_o = cmd_valid_o ? head[31:0]  : 32'h0;
  assign locked_o   = (state_reg == LOCKED);

  assign cnt_inc = {drop, seq_bad};

  generate
    for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
      logic [15:0] cnt_reg;
      always_ff @(posedge clk_ik) begin
        if (!rstn_ir) begin
          cnt_reg <= '0;
        end else if (cnt_inc[gi] && (cnt_reg != 16'hFFFF)) begin
          cnt_reg <= cnt_reg + 16'd1;
        end
      end
    end
  endgenerate

  assign seq_err_cnt_o = g_cnt[0].cnt_reg;
  assign drop_cnt_o    = g_cnt[1].cnt_reg;

`ifdef GBT_CMD_CRC_CHECK_EN
  logic [15:0] crc_cnt_reg;
  always_ff @(posedge clk_ik) begin
    if (!rstn_ir) begin
      crc_cnt_reg <= '0;
    end else if (crc_fail && (crc_cnt_reg != 16'hFFFF)) begin
      crc_cnt_reg <= crc_cnt_reg + 16'd1;
    end
  end
  assign crc_err_cnt_o = crc_cnt_reg;
`else
  assign crc_err_cnt_o = 16'h0000;
`endif

  // sc/ic and the reserved byte are carried but never decoded.
  assign unused_bits = ^{frame_i[83:80], stage_data_reg[15:0], crc_fail};

endmodule

// File: tb/tb_mcoi_gbt_cmd_decoder.sv
// Randomized, self-checking bench for mcoi_gbt_cmd_decoder against a queue-based frame-level reference model.
// Expectations follow GBT_CMD_CRC_CHECK_EN the same way the design does.
module tb_mcoi_gbt_cmd_decoder;

  localparam int DEPTH = 8;
  localparam int LOCKN = 4;
  localparam int UNLKN = 4;

  logic        clk = 1'b0;
  logic        rstn, rx_ready, frame_valid, cmd_ready;
  logic [83:0] frame;
  logic        cmd_valid, locked;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_data;
  logic [15:0] crc_cnt, seq_cnt, drop_cnt;

  always #5 clk = ~clk;

  mcoi_gbt_cmd_decoder #(
    .FIFO_DEPTH(DEPTH), .LOCK_CNT(LOCKN), .UNLOCK_CNT(UNLKN), .HEADER(8'hA5)
  ) dut (
    .clk_ik(clk), .rstn_ir(rstn), .rx_ready_i(rx_ready),
    .frame_valid_i(frame_valid), .frame_i(frame),
    .cmd_valid_o(cmd_valid), .cmd_ready_i(cmd_ready),
    .cmd_addr_o(cmd_addr), .cmd_data_o(cmd_data), .locked_o(locked),
    .crc_err_cnt_o(crc_cnt), .seq_err_cnt_o(seq_cnt), .drop_cnt_o(drop_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_locked;
  int          m_streak;
  bit          m_seq_valid;
  logic [7:0]  m_exp_seq;
  int          m_crc, m_seqe, m_drop, n_pop;
  logic [39:0] m_q[$];
  bit          m_stage_valid;
  logic [79:0] m_stage_data;
  logic [7:0]  next_seq;

  function automatic logic [7:0] crc8_ref(input logic [79:0] d);
    logic [7:0] c = 8'h00;
    for (int k = 9; k >= 1; k--) begin
      c = c ^ d[k*8 +: 8];
      for (int b = 0; b < 8; b++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  function automatic bit crc_ok(input logic [79:0] d);
`ifdef GBT_CMD_CRC_CHECK_EN
    return crc8_ref(d) == d[7:0];
`else
    return d[7:0] == d[7:0];
`endif
  endfunction

  function automatic int sat(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  task automatic model_reset();
    m_locked = 0; m_streak = 0; m_seq_valid = 0; m_exp_seq = 8'h00;
    m_crc = 0; m_seqe = 0; m_drop = 0;
    m_q.delete();
    m_stage_valid = 0; m_stage_data = '0;
  endtask

  // Applies what the design does at one rising edge, given the inputs presented to that edge.
  task automatic model_step();
    bit          pop, push, hdr, was_full;
    logic [39:0] word, popped;
    if (!rstn) begin
      model_reset();
      return;
    end
    push = 0;
    word = '0;
    pop  = (m_q.size() != 0) && cmd_ready;
    if (m_stage_valid && rx_ready) begin
      hdr = (m_stage_data[79:72] == 8'hA5);
      if (m_locked) begin
        if (hdr) begin
          m_streak = 0;
          if (!crc_ok(m_stage_data)) begin
            m_crc = sat(m_crc);
          end else if (m_stage_data[63:56] == 8'h01) begin
            if (m_seq_valid && m_stage_data[71:64] != m_exp_seq) m_seqe = sat(m_seqe);
            m_exp_seq   = m_stage_data[71:64] + 8'd1;
            m_seq_valid = 1;
            push        = 1;
            word        = m_stage_data[55:16];
          end
        end else begin
          m_streak++;
          if (m_streak == UNLKN) begin m_locked = 0; m_streak = 0; end
        end
      end else begin
        if (hdr) begin
          m_streak++;
          if (m_streak == LOCKN) begin m_locked = 1; m_streak = 0; end
        end else begin
          m_streak = 0;
        end
      end
    end
    if (!rx_ready) begin m_locked = 0; m_streak = 0; m_seq_valid = 0; end
    was_full = (m_q.size() == DEPTH);
    if (pop) begin
      popped = m_q.pop_front();
      n_pop++;
      $display("pop   addr=%02h data=%08h", popped[39:32], popped[31:0]);
    end
    if (push) begin
      if (!was_full || pop) m_q.push_back(word);
      else m_drop = sat(m_drop);
    end
    m_stage_valid = frame_valid && rx_ready;
    m_stage_data  = frame[79:0];
  endtask

  task automatic check_outputs();
    check("cmd_valid", cmd_valid, m_q.size() != 0);
    if (m_q.size() != 0) begin
      check("cmd_addr", cmd_addr, m_q[0][39:32]);
      check("cmd_data", cmd_data, m_q[0][31:0]);
    end
    check("locked", locked, m_locked);
    check("crc_err_cnt", crc_cnt, m_crc);
    check("seq_err_cnt", seq_cnt, m_seqe);
    check("drop_cnt", drop_cnt, m_drop);
  endtask

  task automatic tick();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // ---------------- stimulus helpers ----------------
  function automatic logic [83:0] make_frame(input logic [7:0] seq, input logic [7:0] op,
                                             input logic [7:0] addr, input logic [31:0] wd,
                                             input bit bad_hdr, input bit bad_crc);
    logic [79:0] d;
    logic [3:0]  top;
    logic [7:0]  flip;
    top  = 4'($urandom);
    flip = 8'h01 << ($urandom % 8);
    d[79:72] = bad_hdr ? (8'hA5 ^ flip) : 8'hA5;
    d[71:64] = seq;
    d[63:56] = op;
    d[55:48] = addr;
    d[47:16] = wd;
    d[15:8]  = 8'h00;
    d[7:0]   = crc8_ref(d) ^ (bad_crc ? flip : 8'h00);
    return {top, d};
  endfunction

  task automatic send(input logic [83:0] f);
    frame_valid = 1'b1;
    frame       = f;
    tick();
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      frame_valid = 1'b0;
      frame       = {$urandom, $urandom, $urandom};
      tick();
    end
  endtask

  task automatic send_idle(input bit bad_hdr);
    send(make_frame(8'($urandom), 8'h00, 8'($urandom), $urandom, bad_hdr, 1'b0));
  endtask

  task automatic wr(input logic [7:0] seq, input logic [7:0] addr, input logic [31:0] wd);
    send(make_frame(seq, 8'h01, addr, wd, 1'b0, 1'b0));
    next_seq = seq + 8'd1;
  endtask

  task automatic lock_up();
    for (int i = 0; i < LOCKN; i++) send_idle(1'b0);
    gap(2);
  endtask

  initial begin
    logic [7:0] op, sq;
    int         r;
    rstn = 1'b0; rx_ready = 1'b1; frame_valid = 1'b0; cmd_ready = 1'b1;
    frame = '0; next_seq = 8'h00; n_pop = 0;
    model_reset();
    @(posedge clk); model_step(); #1;
    tick();
    check("rst_valid", cmd_valid, 0);
    check("rst_addr", cmd_addr, 0);
    check("rst_data", cmd_data, 0);
    check("rst_locked", locked, 0);
    rstn = 1'b1;

    // Lock acquisition: three good headers are not enough, the fourth is.
    for (int i = 0; i < 3; i++) send_idle(1'b0);
    gap(3);
    check("t1_three_frames", locked, 0);
    send_idle(1'b0);
    gap(2);
    check("t1_four_frames", locked, 1);

    // Single write: valid two clocks after the frame.
    wr(8'h10, 8'h22, 32'hDEADBEEF);
    frame_valid = 1'b0;
    check("t2_n_plus1_valid", cmd_valid, 0);
    tick();
    check("t2_n_plus2_valid", cmd_valid, 1);
    check("t2_addr", cmd_addr, 8'h22);
    check("t2_data", cmd_data, 32'hDEADBEEF);
    tick();
    check("t2_popped", cmd_valid, 0);

    // Sequence errors and wrap.
    wr(8'h12, 8'h33, 32'h12345678);
    gap(3);
    check("t3_seq_err", seq_cnt, 1);
    wr(8'hFF, 8'h44, 32'hCAFEF00D);
    gap(3);
    check("t3_seq_err_ff", seq_cnt, 2);
    wr(8'h00, 8'h55, 32'h0BADC0DE);
    gap(3);
    check("t3_seq_wrap", seq_cnt, 2);
    check("t3_pops", n_pop, 4);

    // Corrupted CRC on a write.
    send(make_frame(8'h01, 8'h01, 8'h66, 32'hA5A5A5A5, 1'b0, 1'b1));
    next_seq = 8'h02;
    gap(3);
`ifdef GBT_CMD_CRC_CHECK_EN
    check("t4_crc_cnt", crc_cnt, 1);
    check("t4_pops", n_pop, 4);
`else
    check("t4_crc_cnt", crc_cnt, 0);
    check("t4_pops", n_pop, 5);
`endif

    // Overflow: 10 writes into an 8-deep FIFO with the consumer stalled.
    cmd_ready = 1'b0;
    for (int i = 0; i < 10; i++) wr(next_seq, 8'(8'h80 + i), $urandom);
    gap(3);
    check("t5_drop", drop_cnt, 2);
    check("t5_full_valid", cmd_valid, 1);
    wr(next_seq, 8'hEE, 32'h55AA55AA);
    cmd_ready   = 1'b1;
    frame_valid = 1'b0;
    tick();
    cmd_ready = 1'b0;
    gap(2);
    check("t5_push_pop_full", drop_cnt, 2);
    cmd_ready = 1'b1;
    gap(12);
    check("t5_drained", cmd_valid, 0);

    // Unlock on bad headers, rx_ready drop, reset with pending commands.
    for (int i = 0; i < UNLKN; i++) send_idle(1'b1);
    gap(2);
    check("t6_unlock", locked, 0);
    lock_up();
    check("t6_relock", locked, 1);
    send_idle(1'b0);
    rx_ready = 1'b0;
    send_idle(1'b0);
    check("t6_rx_ready_low", locked, 0);
    rx_ready = 1'b1;
    gap(1);
    lock_up();
    cmd_ready = 1'b0;
    for (int i = 0; i < 3; i++) wr(next_seq, 8'(8'hC0 + i), $urandom);
    gap(3);
    check("t6_pending", cmd_valid, 1);
    rstn = 1'b0;
    gap(1);
    check("t6_rst_valid", cmd_valid, 0);
    check("t6_rst_seq", seq_cnt, 0);
    check("t6_rst_drop", drop_cnt, 0);
    check("t6_rst_crc", crc_cnt, 0);
    rstn = 1'b1;
    lock_up();

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      r         = int'($urandom % 1000);
      rstn      = (r != 0);
      rx_ready  = ($urandom % 100) >= 2;
      cmd_ready = ($urandom % 100) < 55;
      r         = int'($urandom % 100);
      if (r < 50)      op = 8'h01;
      else if (r < 80) op = 8'h00;
      else             op = 8'h02 + 8'($urandom % 250);
      sq = (($urandom % 10) == 0) ? 8'($urandom) : next_seq;
      if (op == 8'h01) next_seq = sq + 8'd1;
      frame_valid = ($urandom % 100) < 90;
      frame = make_frame(sq, op, 8'($urandom), $urandom,
                         ($urandom % 100) < 5, ($urandom % 100) < 6);
      tick();
    end
    rstn = 1'b1; rx_ready = 1'b1; cmd_ready = 1'b1;
    gap(DEPTH + 4);
    check("end_drained", cmd_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
